// File: rtl/pit_wb_master.sv
// ---------------------------------------------------------------------------
// pit_wb_master
// WISHBONE classic-cycle initiator. Takes one command at a time, runs one
// single read or write cycle, waits for ack with a bounded timeout, and
// returns the read data and an error flag on a response port.
//
// Handshake semantics (both ports): a transfer happens on the rising edge
// where valid and ready are both high; once raised, valid and its payload stay
// stable until that edge; ready may be asserted independently of valid.
//
// Ports
//   wb_clk_i, arst_i          clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready only while idle)
//   cmd_we_i/adr/dat/sel      command payload
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_dat_o, rsp_err_o      read data (0 for writes/timeouts), timeout flag
//   wb_cyc_o..wb_sel_o        registered WISHBONE initiator outputs
//   wb_dat_i, wb_ack_i        WISHBONE target inputs
//   dbg_state_o               current FSM state (0 idle, 1 bus, 2 resp)
// ---------------------------------------------------------------------------
module pit_wb_master #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              wb_clk_i,
  input  logic              arst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [AWIDTH-1:0] cmd_adr_i,
  input  logic [DWIDTH-1:0] cmd_dat_i,
  input  logic [1:0]        cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AWIDTH-1:0] wb_adr_o,
  output logic [DWIDTH-1:0] wb_dat_o,
  output logic [1:0]        wb_sel_o,
  input  logic [DWIDTH-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic [1:0]        dbg_state_o
);

  // Counter must hold the value TIMEOUT; with TIMEOUT 0 it simply wraps unused.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT);
  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
  localparam bit            NARROW     = (DWIDTH == 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] adr_q, adr_d;
  logic [DWIDTH-1:0] dat_q, dat_d;
  logic [1:0]        sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready_o is high in this state, so valid alone means accept.
        if (cmd_valid_i) begin
          state_d = ST_BUS;
          cnt_d   = CW'(1);
          cyc_d   = 1'b1;
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_we_i ? cmd_dat_i : '0;
          sel_d   = NARROW ? 2'b01 : cmd_sel_i;
        end
      end
      ST_BUS: begin
        // Ack is checked first so an ack in the final allowed cycle wins.
        if (wb_ack_i) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wb_dat_i;
          rsp_err_d   = 1'b0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        // Leaving through IDLE guarantees cyc stays low at least one cycle
        // before the next bus cycle.
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pit_wb_master.sv
module tb_pit_wb_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- 16-bit instance ----------------
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [2:0]  cmd_adr;
  logic [15:0] cmd_dat;
  logic [1:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [2:0]  wb_adr;
  logic [15:0] wb_dat_o, wb_dat_i;
  logic [1:0]  wb_sel, dbg_state;

  pit_wb_master #(.DWIDTH(16), .AWIDTH(3), .TIMEOUT(15)) dut (
    .wb_clk_i(clk), .arst_i(arst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .dbg_state_o(dbg_state)
  );

  // Target model: acks in bus cycle ack_at (1 = zero-wait, 2 = one wait
  // state, 0 = never). spur_ack injects an ack regardless of cyc.
  int          ack_at = 0;
  int          bus_cnt;
  logic        spur_ack = 1'b0;
  logic [15:0] rd_data = 16'h0;
  assign wb_ack   = spur_ack | (wb_cyc && (ack_at != 0) && (bus_cnt == ack_at - 1));
  assign wb_dat_i = rd_data;

  always @(posedge clk or posedge arst)
    if (arst) bus_cnt <= 0;
    else if (wb_cyc) bus_cnt <= bus_cnt + 1;
    else bus_cnt <= 0;

  // Bus monitor: payload captured at ack, stability across the cycle.
  logic        first_we, cap_we;
  logic [2:0]  first_adr, cap_adr;
  logic [15:0] first_dat, cap_dat;
  logic [1:0]  first_sel, cap_sel;
  int          unstable = 0;
  int          ack_cnt  = 0;
  int          stb_bad  = 0;
  always @(posedge clk) begin
    if (wb_cyc && bus_cnt == 0) begin
      first_we <= wb_we; first_adr <= wb_adr; first_dat <= wb_dat_o; first_sel <= wb_sel;
    end else if (wb_cyc && ({wb_we, wb_adr, wb_dat_o, wb_sel} !==
                            {first_we, first_adr, first_dat, first_sel})) begin
      unstable <= unstable + 1;
    end
    if (wb_cyc && wb_ack) begin
      cap_we <= wb_we; cap_adr <= wb_adr; cap_dat <= wb_dat_o; cap_sel <= wb_sel;
      ack_cnt <= ack_cnt + 1;
    end
    if (wb_cyc !== wb_stb) stb_bad <= stb_bad + 1;
  end

  // ---------------- 8-bit instance ----------------
  logic       cmd_valid8, cmd_ready8, cmd_we8;
  logic [2:0] cmd_adr8;
  logic [7:0] cmd_dat8;
  logic [1:0] cmd_sel8;
  logic       rsp_valid8, rsp_ready8, rsp_err8;
  logic [7:0] rsp_dat8;
  logic       wb_cyc8, wb_stb8, wb_we8, wb_ack8;
  logic [2:0] wb_adr8;
  logic [7:0] wb_dat_o8, wb_dat_i8;
  logic [1:0] wb_sel8, dbg_state8;

  pit_wb_master #(.DWIDTH(8), .AWIDTH(3), .TIMEOUT(15)) dut8 (
    .wb_clk_i(clk), .arst_i(arst),
    .cmd_valid_i(cmd_valid8), .cmd_ready_o(cmd_ready8), .cmd_we_i(cmd_we8),
    .cmd_adr_i(cmd_adr8), .cmd_dat_i(cmd_dat8), .cmd_sel_i(cmd_sel8),
    .rsp_valid_o(rsp_valid8), .rsp_ready_i(rsp_ready8), .rsp_dat_o(rsp_dat8),
    .rsp_err_o(rsp_err8), .wb_cyc_o(wb_cyc8), .wb_stb_o(wb_stb8), .wb_we_o(wb_we8),
    .wb_adr_o(wb_adr8), .wb_dat_o(wb_dat_o8), .wb_sel_o(wb_sel8),
    .wb_dat_i(wb_dat_i8), .wb_ack_i(wb_ack8), .dbg_state_o(dbg_state8)
  );

  logic [7:0] mem8 [8];
  assign wb_ack8   = wb_cyc8;            // zero-wait target
  assign wb_dat_i8 = mem8[wb_adr8];

  int   sel8_bad = 0, gap8_bad = 0, cyc8_cycles = 0, got8 = 0;
  logic ack_prev8 = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    ack_prev8 <= wb_cyc8 && wb_ack8;
    if (wb_cyc8) cyc8_cycles <= cyc8_cycles + 1;
  end
  always @(negedge clk) begin
    if (wb_cyc8 && wb_sel8 !== 2'b01) sel8_bad++;
    if (ack_prev8 && wb_cyc8) gap8_bad++;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response collector for the 8-bit instance.
  always @(negedge clk) begin
    if (!arst && rsp_valid8 && rsp_ready8) begin
      if (exp_q.size() == 0) begin
        check("rsp8_unexpected", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check($sformatf("rsp8_dat_%0d", got8), rsp_dat8, e);
        check($sformatf("rsp8_err_%0d", got8), rsp_err8, 1'b0);
        got8++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [2:0] adr, input logic [15:0] dat,
                       input logic [1:0] sel, input string tag);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Latency counts edges from the accept edge (inclusive) to rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume(input string tag);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check({tag, "_rsp_valid_drop"}, rsp_valid, 1'b0);
    check({tag, "_ready_again"}, cmd_ready, 1'b1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    int          ack_at;
    logic [15:0] rd;
    int          exp_len;
    int          exp_lat;
    logic        exp_err;
    logic [15:0] exp_rdat;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input string tag);
    int lat, unst0, acks0;
    ack_at = v.ack_at; rd_data = v.rd;
    unst0 = unstable; acks0 = ack_cnt;
    issue(v.we, v.adr, v.dat, v.sel, tag);
    wait_rsp(lat);
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_cyc_len"}, bus_cnt, v.exp_len);
    check({tag, "_cyc_low"}, wb_cyc, 1'b0);
    check({tag, "_err"}, rsp_err, v.exp_err);
    check({tag, "_rdat"}, rsp_dat, v.exp_rdat);
    check({tag, "_stable"}, unstable, unst0);
    if (!v.exp_err) begin
      check({tag, "_acks"}, ack_cnt, acks0 + 1);
      check({tag, "_bus_we"}, cap_we, v.we);
      check({tag, "_bus_adr"}, cap_adr, v.adr);
      check({tag, "_bus_dat"}, cap_dat, v.we ? v.dat : 16'h0);
      check({tag, "_bus_sel"}, cap_sel, v.sel);
    end else begin
      check({tag, "_no_ack"}, ack_cnt, acks0);
    end
    consume(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, t;
    //            we  adr   dat       sel    ack rd        len lat err rdat
    vecs[0] = '{1'b1, 3'd0, 16'h1234, 2'b11, 2,  16'h0000, 2,  3,  1'b0, 16'h0000};
    vecs[1] = '{1'b0, 3'd1, 16'h0000, 2'b11, 1,  16'hBEEF, 1,  2,  1'b0, 16'hBEEF};
    vecs[2] = '{1'b0, 3'd2, 16'h0000, 2'b11, 0,  16'h5A5A, 15, 16, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 3'd3, 16'h0000, 2'b01, 15, 16'h1357, 15, 16, 1'b0, 16'h1357};
    vecs[4] = '{1'b1, 3'd7, 16'hABCD, 2'b10, 1,  16'hFFFF, 1,  2,  1'b0, 16'h0000};
    vecs[5] = '{1'b0, 3'd5, 16'hFFFF, 2'b11, 3,  16'h0F0F, 3,  4,  1'b0, 16'h0F0F};
    vecs[6] = '{1'b0, 3'd6, 16'h0000, 2'b10, 14, 16'hC0DE, 14, 15, 1'b0, 16'hC0DE};
    mem8[0] = 8'h3C; mem8[1] = 8'h91; mem8[2] = 8'h07; mem8[3] = 8'hE5;
    mem8[4] = 8'h5B; mem8[5] = 8'hD2; mem8[6] = 8'h00; mem8[7] = 8'h00;

    cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0; rsp_ready = 0;
    cmd_valid8 = 0; cmd_we8 = 0; cmd_adr8 = 0; cmd_dat8 = 0; cmd_sel8 = 0; rsp_ready8 = 0;

    // Reset state
    arst = 1'b1;
    #12;
    check("rst_cyc", wb_cyc, 1'b0);
    check("rst_stb", wb_stb, 1'b0);
    check("rst_we", wb_we, 1'b0);
    check("rst_adr", wb_adr, 3'd0);
    check("rst_dat", wb_dat_o, 16'h0);
    check("rst_sel", wb_sel, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_dat", rsp_dat, 16'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_cyc8", wb_cyc8, 1'b0);
    @(negedge clk); arst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1'b1);

    // Table of single transactions
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Spurious ack while idle is ignored
    @(negedge clk); spur_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("spur_rsp_valid", rsp_valid, 1'b0);
    check("spur_cyc", wb_cyc, 1'b0);
    check("spur_state", dbg_state, 2'd0);
    @(negedge clk); spur_ack = 1'b0;

    // Response back-pressure: rsp held, new command ignored
    ack_at = 1; rd_data = 16'h4242;
    issue(1'b0, 3'd4, 16'h0, 2'b11, "bp");
    wait_rsp(lat);
    check("bp_latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 3'd6; cmd_dat = 16'h6666; cmd_sel = 2'b11;
      end
      check($sformatf("bp_valid_%0d", k), rsp_valid, 1'b1);
      check($sformatf("bp_dat_%0d", k), rsp_dat, 16'h4242);
      check($sformatf("bp_err_%0d", k), rsp_err, 1'b0);
      check($sformatf("bp_cmd_ready_%0d", k), cmd_ready, 1'b0);
      check($sformatf("bp_cyc_%0d", k), wb_cyc, 1'b0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check("bp_hs_valid", rsp_valid, 1'b0);
    check("bp_hs_ready", cmd_ready, 1'b1);
    check("bp_hs_cyc", wb_cyc, 1'b0);
    @(posedge clk); #1; cmd_valid = 1'b0;
    check("bp_next_cyc", wb_cyc, 1'b1);
    check("bp_next_we", wb_we, 1'b1);
    check("bp_next_adr", wb_adr, 3'd6);
    check("bp_next_dat", wb_dat_o, 16'h6666);
    wait_rsp(lat);
    check("bp_next_lat", lat, 2);
    check("bp_next_err", rsp_err, 1'b0);
    check("bp_next_rdat", rsp_dat, 16'h0);
    consume("bp_next");

    // Reset in bus cycle 1: cycle dropped at once, no response
    ack_at = 0;
    issue(1'b0, 3'd2, 16'h0, 2'b11, "ar");
    check("ar_cyc_before", wb_cyc, 1'b1);
    #1 arst = 1'b1;
    #1;
    check("ar_cyc", wb_cyc, 1'b0);
    check("ar_stb", wb_stb, 1'b0);
    check("ar_rsp_valid", rsp_valid, 1'b0);
    check("ar_state", dbg_state, 2'd0);
    #1 arst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ar_no_rsp", rsp_valid, 1'b0);
    check("ar_idle_cyc", wb_cyc, 1'b0);
    check("ar_ready", cmd_ready, 1'b1);
    run_vec(vecs[1], "ar_after");
    check("cyc_eq_stb", stb_bad, 0);

    // 8-bit instance: six reads offered back to back
    rsp_ready8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_valid8 = 1'b1; cmd_we8 = 1'b0; cmd_adr8 = 3'(i); cmd_sel8 = 2'b10; cmd_dat8 = 8'hFF;
      t = 0;
      while (!cmd_ready8 && t < 50) begin @(negedge clk); t++; end
      check($sformatf("n8_ready_%0d", i), cmd_ready8, 1'b1);
      exp_q.push_back(mem8[i]);
      @(posedge clk); #1;
    end
    cmd_valid8 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("n8_rsp_count", got8, 6);
    check("n8_queue_empty", exp_q.size(), 0);
    check("n8_sel_forced", sel8_bad, 0);
    check("n8_gap", gap8_bad, 0);
    check("n8_cyc_cycles", cyc8_cycles, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
